// File: rtl/cmos_dvp_rx_if.sv
// Camera byte bus into the receiver and the packed pixel stream out of it.
// master: camera/sink side (drives the camera pins, consumes the video).
// slave:  the receiver.
interface cmos_dvp_rx_if;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic        out_vs;
    logic        out_de;
    logic [15:0] out_data;
    logic [11:0] out_x;
    logic [11:0] out_y;

    modport master (
        output cmos_vsync, cmos_href, cmos_data,
        input  out_vs, out_de, out_data, out_x, out_y
    );

    modport slave (
        input  cmos_vsync, cmos_href, cmos_data,
        output out_vs, out_de, out_data, out_x, out_y
    );
endinterface

// File: rtl/cmos_dvp_rx.sv
// DVP camera receiver: registers the camera bus, drops start-up frames,
// packs byte pairs into RGB565 pixels and checks frame geometry.
//
// state | meaning
// IDLE  | after reset, waiting for the first vsync rise
// SKIP  | discarding start-up frames, counting vsync rises
// RUN   | delivering pixels; left only by reset
module cmos_dvp_rx #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int SKIP_FRAMES = 10,
    parameter int HI_FIRST    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    cmos_dvp_rx_if.slave dvp,
    output logic        frame_done,
    output logic        size_err,
    output logic [7:0]  frame_cnt
);
    typedef enum logic [1:0] {IDLE, SKIP, RUN} state_t;

    localparam logic [7:0]  SKIP_N = 8'(SKIP_FRAMES);
    localparam logic [11:0] H_N    = 12'(H_ACTIVE);
    localparam logic [11:0] V_N    = 12'(V_ACTIVE);
    localparam logic [11:0] H_MAX  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_MAX  = 12'(V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic [7:0]  skip_cnt_q, skip_cnt_d;
    logic        vs_r1_q, vs_r2_q, href_r1_q, href_r2_q;
    logic [7:0]  data_r1_q;
    logic        phase_q, phase_d;
    logic [7:0]  byte_q, byte_d;
    logic [11:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic        err_q, err_d;
    logic        pix_vld_q, pix_vld_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        out_vs_q, out_vs_d, out_de_q, out_de_d;
    logic [15:0] out_data_q, out_data_d;
    logic [11:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic        frame_done_q, frame_done_d, size_err_q, size_err_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        vs_rise, href_fall;

    assign vs_rise   = vs_r1_q & ~vs_r2_q;
    assign href_fall = ~href_r1_q & href_r2_q;

    // Next-state logic: count skipped frames, enter RUN once enough have passed.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        case (state_q)
            IDLE: if (vs_rise) state_d = (SKIP_N == 8'd0) ? RUN : SKIP;
            SKIP: if (vs_rise) begin
                skip_cnt_d = skip_cnt_q + 8'd1;
                if (skip_cnt_d == SKIP_N) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Byte packing, position counters, geometry checking and output staging.
    always_comb begin
        phase_d      = phase_q;
        byte_d       = byte_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        err_d        = err_q;
        pix_vld_d    = 1'b0;
        pix_data_d   = pix_data_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_done_d = 1'b0;
        size_err_d   = err_q;
        frame_cnt_d  = frame_cnt_q;
        if (state_q == RUN) begin
            if (vs_rise) begin
                // Report the closing frame, then start the new one clean.
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
                size_err_d   = err_q | (y_cnt_q != V_N);
                x_cnt_d      = '0;
                y_cnt_d      = '0;
                err_d        = 1'b0;
                phase_d      = 1'b0;
            end else if (href_r1_q && vs_r1_q) begin
                err_d   = 1'b1;
                phase_d = 1'b0;
            end else if (href_r1_q) begin
                if (!phase_q) begin
                    byte_d  = data_r1_q;
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    pix_vld_d  = 1'b1;
                    pix_data_d = (HI_FIRST != 0) ? {byte_q, data_r1_q} : {data_r1_q, byte_q};
                    pix_x_d    = (x_cnt_q < H_N) ? x_cnt_q : H_MAX;
                    pix_y_d    = (y_cnt_q < V_N) ? y_cnt_q : V_MAX;
                    // x stops at H_N so overlong lines can't wrap back to a legal count.
                    if (x_cnt_q < H_N) x_cnt_d = x_cnt_q + 12'd1;
                    else               err_d   = 1'b1;
                    if (y_cnt_q >= V_N) err_d = 1'b1;
                end
            end else if (href_fall) begin
                phase_d = 1'b0;
                if (phase_q || (x_cnt_q != H_N)) err_d = 1'b1;
                if ((x_cnt_q != 12'd0) && (y_cnt_q < V_N)) y_cnt_d = y_cnt_q + 12'd1;
                x_cnt_d = '0;
            end
        end else begin
            phase_d = 1'b0;
            x_cnt_d = '0;
            y_cnt_d = '0;
            err_d   = 1'b0;
        end
        out_vs_d   = vs_r1_q & (state_d == RUN);
        out_de_d   = pix_vld_q;
        out_data_d = pix_vld_q ? pix_data_q : out_data_q;
        out_x_d    = pix_vld_q ? pix_x_q : out_x_q;
        out_y_d    = pix_vld_q ? pix_y_q : out_y_q;
    end

    // All state, async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            skip_cnt_q   <= '0;
            vs_r1_q      <= 1'b0;
            vs_r2_q      <= 1'b0;
            href_r1_q    <= 1'b0;
            href_r2_q    <= 1'b0;
            data_r1_q    <= '0;
            phase_q      <= 1'b0;
            byte_q       <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            err_q        <= 1'b0;
            pix_vld_q    <= 1'b0;
            pix_data_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            out_vs_q     <= 1'b0;
            out_de_q     <= 1'b0;
            out_data_q   <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
            size_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            vs_r1_q      <= dvp.cmos_vsync;
            vs_r2_q      <= vs_r1_q;
            href_r1_q    <= dvp.cmos_href;
            href_r2_q    <= href_r1_q;
            data_r1_q    <= dvp.cmos_data;
            phase_q      <= phase_d;
            byte_q       <= byte_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            err_q        <= err_d;
            pix_vld_q    <= pix_vld_d;
            pix_data_q   <= pix_data_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            out_vs_q     <= out_vs_d;
            out_de_q     <= out_de_d;
            out_data_q   <= out_data_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
            size_err_q   <= size_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dvp.out_vs   = out_vs_q;
    assign dvp.out_de   = out_de_q;
    assign dvp.out_data = out_data_q;
    assign dvp.out_x    = out_x_q;
    assign dvp.out_y    = out_y_q;
    assign frame_done   = frame_done_q;
    assign size_err     = size_err_q;
    assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_cmos_dvp_rx.sv
// Directed bench: dut_a (SKIP=2, 4x2, high byte first) covers skipping,
// geometry errors and reset; dut_b (SKIP=0, 2x1, low byte first) covers
// byte order and frame counter wrap.
module tb_cmos_dvp_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic cam_vs = 1'b0, cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;

    cmos_dvp_rx_if a_if ();
    cmos_dvp_rx_if b_if ();
    logic a_fd, a_err, b_fd, b_err;
    logic [7:0] a_fc, b_fc;

    assign a_if.cmos_vsync = sel ? 1'b0 : cam_vs;
    assign a_if.cmos_href  = sel ? 1'b0 : cam_href;
    assign a_if.cmos_data  = sel ? 8'h00 : cam_data;
    assign b_if.cmos_vsync = sel ? cam_vs : 1'b0;
    assign b_if.cmos_href  = sel ? cam_href : 1'b0;
    assign b_if.cmos_data  = sel ? cam_data : 8'h00;

    cmos_dvp_rx #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(2), .HI_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .dvp(a_if.slave),
        .frame_done(a_fd), .size_err(a_err), .frame_cnt(a_fc));
    cmos_dvp_rx #(.H_ACTIVE(2), .V_ACTIVE(1), .SKIP_FRAMES(0), .HI_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .dvp(b_if.slave),
        .frame_done(b_fd), .size_err(b_err), .frame_cnt(b_fc));

    always #5 clk = ~clk;

    logic        o_de;
    logic [15:0] o_data;
    logic [11:0] o_x;
    assign o_de   = sel ? b_if.out_de : a_if.out_de;
    assign o_data = sel ? b_if.out_data : a_if.out_data;
    assign o_x    = sel ? b_if.out_x : a_if.out_x;

    // Per-frame bookkeeping for dut_a, latched at each frame_done.
    int de_a = 0, vs_a = 0, fd_a = 0, fd_b = 0, pix_a = 0, lpix_a = 0;
    logic [11:0] mx_a = 0, my_a = 0, lmx_a = 0, lmy_a = 0;
    logic [15:0] last_data_a = 0;
    logic lerr_a = 0, lerr_b = 0;
    always @(negedge clk) begin
        if (a_if.out_vs) vs_a <= vs_a + 1;
        if (b_fd) begin
            fd_b   <= fd_b + 1;
            lerr_b <= b_err;
        end
        if (a_if.out_de) begin
            de_a        <= de_a + 1;
            pix_a       <= pix_a + 1;
            last_data_a <= a_if.out_data;
            if (a_if.out_x > mx_a) mx_a <= a_if.out_x;
            if (a_if.out_y > my_a) my_a <= a_if.out_y;
        end
        if (a_fd) begin
            fd_a   <= fd_a + 1;
            lerr_a <= a_err;
            lpix_a <= pix_a;
            lmx_a  <= mx_a;
            lmy_a  <= my_a;
            pix_a  <= 0;
            mx_a   <= 0;
            my_a   <= 0;
        end
    end

    int passed = 0, total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic vsync_pulse();
        cam_vs = 1'b1;
        repeat (3) @(negedge clk);
        cam_vs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            cam_href = 1'b1;
            cam_data = base + 8'(i);
            @(negedge clk);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    // Bytes F8,1F,A5,3C: first pixel due two edges after 1F, second after 3C.
    task automatic pair_probe(input string tag, input logic [15:0] exp0, input logic [15:0] exp1);
        cam_href = 1'b1;
        cam_data = 8'hF8; @(negedge clk);
        cam_data = 8'h1F; @(negedge clk);
        cam_data = 8'hA5; @(negedge clk);
        check({tag, "_de_early"}, 32'(o_de), 32'd0);
        cam_data = 8'h3C; @(negedge clk);
        check({tag, "_de0"}, 32'(o_de), 32'd1);
        check({tag, "_data0"}, 32'(o_data), 32'(exp0));
        check({tag, "_x0"}, 32'(o_x), 32'd0);
        cam_href = 1'b0;
        cam_data = 8'h00; @(negedge clk);
        check({tag, "_de_gap"}, 32'(o_de), 32'd0);
        @(negedge clk);
        check({tag, "_de1"}, 32'(o_de), 32'd1);
        check({tag, "_data1"}, 32'(o_data), 32'(exp1));
        check({tag, "_x1"}, 32'(o_x), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    int de0;
    initial begin
        repeat (3) @(negedge clk);
        check("rst_de", 32'(a_if.out_de), 32'd0);
        check("rst_vs", 32'(a_if.out_vs), 32'd0);
        check("rst_data", 32'(a_if.out_data), 32'd0);
        check("rst_fc", 32'(a_fc), 32'd0);
        check("rst_err_fd", {30'd0, a_err, a_fd}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two frames discarded, third vsync enters RUN.
        vsync_pulse(); send_line(8, 8'h40); send_line(8, 8'h50);
        vsync_pulse(); send_line(8, 8'h60); send_line(8, 8'h70);
        vsync_pulse();
        check("skip_no_de", 32'(de_a), 32'd0);
        check("run_vs_cycles", 32'(vs_a), 32'd3);
        check("entry_no_fd", 32'(fd_a), 32'd0);
        send_line(8, 8'h00); send_line(8, 8'h10);
        vsync_pulse();
        check("f3_fd", 32'(fd_a), 32'd1);
        check("f3_pix", 32'(lpix_a), 32'd8);
        check("f3_err", 32'(lerr_a), 32'd0);
        check("f3_maxx", 32'(lmx_a), 32'd3);
        check("f3_maxy", 32'(lmy_a), 32'd1);
        check("f3_last", 32'(last_data_a), 32'h1617);
        send_line(8, 8'h80); send_line(8, 8'h90);
        vsync_pulse();
        check("f4_fd", 32'(fd_a), 32'd2);
        check("f4_fc", 32'(a_fc), 32'd2);
        check("f4_err", 32'(lerr_a), 32'd0);
        check("f4_de_total", 32'(de_a), 32'd16);

        // Byte order/latency, short line and short frame.
        pair_probe("hi_first", 16'hF81F, 16'hA53C);
        vsync_pulse();
        check("probe_err", 32'(lerr_a), 32'd1);
        check("probe_pix", 32'(lpix_a), 32'd2);

        // Odd byte count then a clean frame.
        send_line(7, 8'h20); send_line(8, 8'h30);
        vsync_pulse();
        check("odd_pix", 32'(lpix_a), 32'd7);
        check("odd_err", 32'(lerr_a), 32'd1);
        send_line(8, 8'h00); send_line(8, 8'h10);
        vsync_pulse();
        check("clean_err", 32'(lerr_a), 32'd0);
        check("clean_fd", 32'(fd_a), 32'd5);

        // One line short of V_ACTIVE.
        send_line(8, 8'h00);
        vsync_pulse();
        check("shortv_err", 32'(lerr_a), 32'd1);
        check("shortv_maxy", 32'(lmy_a), 32'd0);
        check("shortv_fc", 32'(a_fc), 32'd6);

        // Reset mid-line after three pixels.
        cam_href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cam_data = 8'(8'hC0 + i);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_de", 32'(a_if.out_de), 32'd0);
        check("midrst_data", 32'(a_if.out_data), 32'd0);
        check("midrst_xy", {8'd0, a_if.out_x, a_if.out_y}, 32'd0);
        check("midrst_fc", 32'(a_fc), 32'd0);
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        de0 = de_a;
        vsync_pulse(); send_line(8, 8'h00); send_line(8, 8'h10);
        vsync_pulse(); send_line(8, 8'h00); send_line(8, 8'h10);
        check("reskip_no_de", 32'(de_a - de0), 32'd0);
        vsync_pulse();
        check("reskip_fc0", 32'(a_fc), 32'd0);
        send_line(8, 8'h00); send_line(8, 8'h10);
        vsync_pulse();
        check("reskip_de", 32'(de_a - de0), 32'd8);
        check("reskip_fc1", 32'(a_fc), 32'd1);
        check("reskip_err", 32'(lerr_a), 32'd0);

        // dut_b: low byte first, no skip, frame counter wrap.
        sel = 1'b1;
        repeat (2) @(negedge clk);
        vsync_pulse();
        check("b_entry_fd", 32'(fd_b), 32'd0);
        pair_probe("lo_first", 16'h1FF8, 16'h3CA5);
        vsync_pulse();
        check("b_fc1", 32'(b_fc), 32'd1);
        check("b_err", 32'(lerr_b), 32'd0);
        for (int f = 0; f < 254; f++) begin
            send_line(4, 8'h10);
            vsync_pulse();
        end
        check("b_fc255", 32'(b_fc), 32'd255);
        send_line(4, 8'h10);
        vsync_pulse();
        check("b_fc_wrap", 32'(b_fc), 32'd0);
        check("b_fd256", 32'(fd_b), 32'd256);
        check("b_wrap_err", 32'(lerr_b), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
